// File: rtl/argmax_16_16.sv
// Streaming argmax over groups of N signed elements. The result holds the index and value of the largest element.
// Optional ARGMAX_TIE_LAST_EN: ties resolve to the highest index instead of the lowest.
module argmax_16_16 #(
   parameter  int T  = 16,
   parameter  int N  = 16,
   localparam int IW = $clog2(N)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                input_valid,
   output logic                input_ready,
   input  logic signed [T-1:0] input_data,
   output logic                output_valid,
   input  logic                output_ready,
   output logic [IW-1:0]       output_index,
   output logic signed [T-1:0] output_value
);

   logic [IW-1:0]       cnt_q, cnt_d;
   logic signed [T-1:0] max_q, max_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                ov_q, ov_d;
   logic [IW-1:0]       oi_q, oi_d;
   logic signed [T-1:0] oval_q, oval_d;

   logic                last, first, better, accept, drain;
   logic signed [T-1:0] cand_max;
   logic [IW-1:0]       cand_idx;

   always_comb begin
      last  = (cnt_q == IW'(N - 1));
      first = (cnt_q == '0);
`ifdef ARGMAX_TIE_LAST_EN
      better = (input_data >= max_q);
`else
      better = (input_data > max_q);
`endif
      cand_max = (first || better) ? input_data : max_q;
      cand_idx = first ? '0 : (better ? cnt_q : idx_q);

      // The last element may only enter when the output register is free or being drained now.
      input_ready = !(last && ov_q && !output_ready);
      accept      = input_valid && input_ready;
      drain       = ov_q && output_ready;

      cnt_d  = cnt_q;
      max_d  = max_q;
      idx_d  = idx_q;
      ov_d   = ov_q;
      oi_d   = oi_q;
      oval_d = oval_q;

      if (drain) begin
         ov_d = 1'b0;
      end
      if (accept) begin
         max_d = cand_max;
         idx_d = cand_idx;
         if (last) begin
            cnt_d  = '0;
            ov_d   = 1'b1;
            oi_d   = cand_idx;
            oval_d = cand_max;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         max_q  <= '0;
         idx_q  <= '0;
         ov_q   <= 1'b0;
         oi_q   <= '0;
         oval_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         max_q  <= max_d;
         idx_q  <= idx_d;
         ov_q   <= ov_d;
         oi_q   <= oi_d;
         oval_q <= oval_d;
      end
   end

   assign output_valid = ov_q;
   assign output_index = oi_q;
   assign output_value = oval_q;

endmodule

// File: tb/tb_argmax_16_16.sv
// Bench for argmax_16_16: directed vectors, backpressure, async reset and a long random run
// checked against a queue-based argmax model.
module tb_argmax_16_16;
   localparam int N = 16;

   typedef struct {
      logic [3:0]  idx;
      logic [15:0] val;
   } res_t;

   logic        clk;
   logic        reset;
   logic        input_valid;
   logic        input_ready;
   logic [15:0] input_data;
   logic        output_valid;
   logic        output_ready;
   logic [3:0]  output_index;
   logic [15:0] output_value;

   int pass_cnt = 0;
   int total    = 0;

   logic [15:0] elem_q[$];
   res_t        exp_q[$];
   logic [15:0] vec[16];
   logic        acc;

   argmax_16_16 dut (
      .clk         (clk),
      .reset       (reset),
      .input_valid (input_valid),
      .input_ready (input_ready),
      .input_data  (input_data),
      .output_valid(output_valid),
      .output_ready(output_ready),
      .output_index(output_index),
      .output_value(output_value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic res_t ref_argmax(input logic [15:0] v[$]);
      res_t r;
      int   best = 0;
      for (int i = 1; i < v.size(); i++) begin
`ifdef ARGMAX_TIE_LAST_EN
         if ($signed(v[i]) >= $signed(v[best])) best = i;
`else
         if ($signed(v[i]) > $signed(v[best])) best = i;
`endif
      end
      r.idx = 4'(best);
      r.val = v[best];
      return r;
   endfunction

   // One clock: drive at negedge, check against the model, then advance the model on posedge.
   task automatic cycle(input logic iv, input logic [15:0] d, input logic ordy, output logic accepted);
      logic hs;
      logic exp_rdy;
      @(negedge clk);
      input_valid  = iv;
      input_data   = iv ? d : 16'hxxxx;
      output_ready = ordy;
      #1;
      exp_rdy = !(elem_q.size() == N - 1 && exp_q.size() != 0 && !ordy);
      check("input_ready", 32'(input_ready), 32'(exp_rdy));
      check("output_valid", 32'(output_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         check("output_index", 32'(output_index), 32'(exp_q[0].idx));
         check("output_value", 32'(output_value), 32'(exp_q[0].val));
      end
      accepted = iv && input_ready;
      hs       = output_valid && ordy;
      @(posedge clk);
      if (hs && exp_q.size() != 0) void'(exp_q.pop_front());
      if (accepted) begin
         elem_q.push_back(d);
         if (elem_q.size() == N) begin
            exp_q.push_back(ref_argmax(elem_q));
            elem_q.delete();
         end
      end
   endtask

   task automatic send_vec(input logic [15:0] v[16], input logic ordy);
      int i = 0;
      int stalls = 0;
      logic a;
      while (i < N) begin
         cycle(1'b1, v[i], ordy, a);
         if (a) i++;
         else stalls++;
         if (stalls > 40) begin
            total++;
            $error("FAIL send_timeout observed=%0d accepted expected=%0d", i, N);
            break;
         end
      end
   endtask

   task automatic expect_res(input string tag, input logic [3:0] idx, input logic [15:0] val);
      #2;
      check({tag, "_valid"}, 32'(output_valid), 32'd1);
      check({tag, "_index"}, 32'(output_index), 32'(idx));
      check({tag, "_value"}, 32'(output_value), 32'(val));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_in_ready"}, 32'(input_ready), 32'd1);
      check({tag, "_out_valid"}, 32'(output_valid), 32'd0);
      check({tag, "_out_index"}, 32'(output_index), 32'd0);
      check({tag, "_out_value"}, 32'(output_value), 32'd0);
   endtask

   initial begin
      int elems;
      int cyc;
      logic iv, ordy;
      logic [15:0] d;

      reset        = 1'b0;
      input_valid  = 1'b0;
      input_data   = '0;
      output_ready = 1'b0;
      #12;
      check_reset_state("rst0");
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < N; i++) vec[i] = 16'(i);
      send_vec(vec, 1'b1);
      expect_res("ascending", 4'd15, 16'h000F);
      cycle(1'b0, '0, 1'b1, acc);

      for (int i = 0; i < N; i++) vec[i] = 16'hFFFB;
      send_vec(vec, 1'b1);
`ifdef ARGMAX_TIE_LAST_EN
      expect_res("ties", 4'd15, 16'hFFFB);
`else
      expect_res("ties", 4'd0, 16'hFFFB);
`endif
      cycle(1'b0, '0, 1'b1, acc);

      for (int i = 0; i < N; i++) vec[i] = 16'h0000;
      vec[3] = 16'h7FFF;
      vec[9] = 16'h8000;
      send_vec(vec, 1'b1);
      expect_res("sign_pos", 4'd3, 16'h7FFF);
      cycle(1'b0, '0, 1'b1, acc);

      for (int i = 0; i < N; i++) vec[i] = 16'(-(i + 2));
      vec[7] = 16'hFFFF;
      send_vec(vec, 1'b1);
      expect_res("sign_neg", 4'd7, 16'hFFFF);
      cycle(1'b0, '0, 1'b1, acc);

      // Backpressure: result 1 held while vector 2 streams in.
      for (int i = 0; i < N; i++) vec[i] = 16'h0000;
      vec[3] = 16'h7FFF;
      vec[9] = 16'h8000;
      send_vec(vec, 1'b0);
      expect_res("bp_res1", 4'd3, 16'h7FFF);
      for (int i = 0; i < N; i++) vec[i] = 16'(i * 3);
      vec[10] = 16'h0500;
      for (int i = 0; i < N - 1; i++) begin
         cycle(1'b1, vec[i], 1'b0, acc);
         check("bp_accept", 32'(acc), 32'd1);
      end
      expect_res("bp_hold", 4'd3, 16'h7FFF);
      cycle(1'b1, vec[N-1], 1'b0, acc);
      check("bp_stall", 32'(acc), 32'd0);
      cycle(1'b1, vec[N-1], 1'b0, acc);
      check("bp_stall2", 32'(acc), 32'd0);
      cycle(1'b1, vec[N-1], 1'b1, acc);
      check("bp_drain_accept", 32'(acc), 32'd1);
      expect_res("bp_res2", 4'd10, 16'h0500);
      cycle(1'b0, '0, 1'b1, acc);
      cycle(1'b0, '0, 1'b1, acc);

      // Asynchronous reset mid-vector, partial vector discarded.
      for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0200 + 16'(i), 1'b1, acc);
      input_valid = 1'b0;
      #3;
      reset = 1'b0;
      #1;
      check_reset_state("rst_mid");
      elem_q.delete();
      exp_q.delete();
      #3;
      reset = 1'b1;
      for (int i = 0; i < N; i++) vec[i] = 16'(i);
      vec[2] = 16'h0100;
      send_vec(vec, 1'b1);
      expect_res("post_reset", 4'd2, 16'h0100);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, acc);
      check("post_reset_single", 32'(exp_q.size()), 32'd0);

      // Random stream of 1000 vectors with random valid/ready.
      elems = 0;
      cyc   = 0;
      while (elems < 1000 * N && cyc < 80000) begin
         iv   = ($urandom % 4) != 0;
         ordy = ($urandom % 3) != 0;
         d    = (($urandom % 4) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
         cycle(iv, d, ordy, acc);
         if (acc) elems++;
         cyc++;
      end
      if (elems < 1000 * N) begin
         total++;
         $error("FAIL random_timeout observed=%0d elements expected=%0d", elems, 1000 * N);
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, acc);
      check("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
